// File: rtl/uart_frame_bridge.sv
// Byte-stream / word-frame bridge: packs received UART bytes into frames for the
// coprocessor and serialises coprocessor result words back into UART bytes.
module uart_frame_bridge #(
  parameter int DBITS           = 8,
  parameter int FRAME_BYTES     = 4,
  parameter int OUT_FRAME_BYTES = 4,
  parameter bit MSB_FIRST       = 1'b0,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DBITS-1:0]                   rx_byte,
  input  logic                               rx_byte_valid,
  output logic [FRAME_BYTES*DBITS-1:0]       frame_out,
  output logic                               frame_out_valid,
  input  logic                               frame_out_ready,
  input  logic [OUT_FRAME_BYTES*DBITS-1:0]   frame_in,
  input  logic                               frame_in_valid,
  output logic                               frame_in_ready,
  output logic [DBITS-1:0]                   tx_byte,
  output logic                               tx_byte_valid,
  input  logic                               tx_byte_ready,
  output logic                               rx_timeout,
  output logic                               tx_done,
  output logic [7:0]                         overrun_cnt
);

  localparam int FW  = FRAME_BYTES * DBITS;
  localparam int OW  = OUT_FRAME_BYTES * DBITS;
  localparam int IW  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int OIW = (OUT_FRAME_BYTES > 1) ? $clog2(OUT_FRAME_BYTES) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0]  LAST     = IW'(FRAME_BYTES - 1);
  localparam logic [OIW-1:0] OLAST    = OIW'(OUT_FRAME_BYTES - 1);
  localparam logic [TW-1:0]  TMR_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {R_COLLECT, R_HOLD} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  rx_state_t       rx_state_q, rx_state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [7:0]      ovr_q, ovr_d;
  tx_state_t       tx_state_q, tx_state_d;
  logic [OIW-1:0]  oidx_q, oidx_d;
  logic [OW-1:0]   sh_q, sh_d;
  logic            alive_q, alive_d;

  logic [IW-1:0]   lane;
  logic [OIW-1:0]  olane;
  int              rx_base;
  int              tx_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_COLLECT;
      idx_q      <= '0;
      timer_q    <= '0;
      frame_q    <= '0;
      ovr_q      <= '0;
      tx_state_q <= T_IDLE;
      oidx_q     <= '0;
      sh_q       <= '0;
      alive_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      frame_q    <= frame_d;
      ovr_q      <= ovr_d;
      tx_state_q <= tx_state_d;
      oidx_q     <= oidx_d;
      sh_q       <= sh_d;
      alive_q    <= alive_d;
    end
  end

  // RX: in R_HOLD idx_q is always 0, so lane also addresses byte 0 of the next frame.
  always_comb begin
    rx_state_d = rx_state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    frame_d    = frame_q;
    ovr_d      = ovr_q;
    rx_timeout = 1'b0;
    lane       = MSB_FIRST ? (LAST - idx_q) : idx_q;
    rx_base    = int'(lane) * DBITS;
    case (rx_state_q)
      R_COLLECT: begin
        if (rx_byte_valid) begin
          frame_d[rx_base +: DBITS] = rx_byte;
          timer_d = '0;
          if (idx_q == LAST) begin
            idx_d      = '0;
            rx_state_d = R_HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0 && idx_q != '0) begin
          if (timer_q == TMR_LAST) begin
            idx_d      = '0;
            timer_d    = '0;
            frame_d    = '0;
            rx_timeout = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      R_HOLD: begin
        if (frame_out_ready) begin
          frame_d    = '0;
          timer_d    = '0;
          rx_state_d = R_COLLECT;
          if (rx_byte_valid) begin
            frame_d[rx_base +: DBITS] = rx_byte;
            if (FRAME_BYTES == 1) rx_state_d = R_HOLD;
            else                  idx_d      = IW'(1);
          end
        end else if (rx_byte_valid && ovr_q != 8'hFF) begin
          ovr_d = ovr_q + 1'b1;
        end
      end
      default: rx_state_d = R_COLLECT;
    endcase
  end

  // TX: alive_q keeps frame_in_ready low until the first clock after reset release.
  always_comb begin
    tx_state_d     = tx_state_q;
    oidx_d         = oidx_q;
    sh_d           = sh_q;
    alive_d        = 1'b1;
    tx_done        = 1'b0;
    olane          = MSB_FIRST ? (OLAST - oidx_q) : oidx_q;
    tx_base        = int'(olane) * DBITS;
    frame_in_ready = alive_q && (tx_state_q == T_IDLE);
    tx_byte_valid  = (tx_state_q == T_SEND);
    tx_byte        = tx_byte_valid ? sh_q[tx_base +: DBITS] : '0;
    case (tx_state_q)
      T_IDLE: begin
        if (frame_in_valid && alive_q) begin
          sh_d       = frame_in;
          oidx_d     = '0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_byte_ready) begin
          if (oidx_q == OLAST) begin
            tx_done    = 1'b1;
            oidx_d     = '0;
            tx_state_d = T_IDLE;
          end else begin
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign frame_out       = frame_q;
  assign frame_out_valid = (rx_state_q == R_HOLD);
  assign overrun_cnt     = ovr_q;

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Directed bench for uart_frame_bridge: an LSB-first instance with a short timeout
// and an MSB-first instance without timeout share the same stimulus.
module tb_uart_frame_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        frame_out_ready;
  logic [31:0] frame_in;
  logic        frame_in_valid;
  logic        tx_byte_ready;

  logic [31:0] a_frame_out, b_frame_out;
  logic        a_frame_out_valid, b_frame_out_valid;
  logic        a_frame_in_ready, b_frame_in_ready;
  logic [7:0]  a_tx_byte, b_tx_byte;
  logic        a_tx_byte_valid, b_tx_byte_valid;
  logic        a_rx_timeout, b_rx_timeout;
  logic        a_tx_done, b_tx_done;
  logic [7:0]  a_overrun_cnt, b_overrun_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_frame_bridge #(.DBITS(8), .FRAME_BYTES(4), .OUT_FRAME_BYTES(4),
                      .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_out(a_frame_out), .frame_out_valid(a_frame_out_valid),
    .frame_out_ready(frame_out_ready),
    .frame_in(frame_in), .frame_in_valid(frame_in_valid), .frame_in_ready(a_frame_in_ready),
    .tx_byte(a_tx_byte), .tx_byte_valid(a_tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_timeout(a_rx_timeout), .tx_done(a_tx_done), .overrun_cnt(a_overrun_cnt)
  );

  uart_frame_bridge #(.DBITS(8), .FRAME_BYTES(4), .OUT_FRAME_BYTES(4),
                      .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_out(b_frame_out), .frame_out_valid(b_frame_out_valid),
    .frame_out_ready(frame_out_ready),
    .frame_in(frame_in), .frame_in_valid(frame_in_valid), .frame_in_ready(b_frame_in_ready),
    .tx_byte(b_tx_byte), .tx_byte_valid(b_tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_timeout(b_rx_timeout), .tx_done(b_tx_done), .overrun_cnt(b_overrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tx [4];
    int tcount;
    int tfirst;
    int k;

    rst_n = 1'b0; rx_byte = '0; rx_byte_valid = 1'b0; frame_out_ready = 1'b1;
    frame_in = '0; frame_in_valid = 1'b0; tx_byte_ready = 1'b0;

    #2;
    check_eq("rst_frame_in_ready", a_frame_in_ready, 1'b0);
    check_eq("rst_frame_out_valid", a_frame_out_valid, 1'b0);
    check_eq("rst_frame_out", a_frame_out, 32'h0);
    check_eq("rst_tx_byte_valid", a_tx_byte_valid, 1'b0);
    check_eq("rst_overrun", a_overrun_cnt, 8'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1 check_eq("release_ready_low", a_frame_in_ready, 1'b0);
    tick();
    #1 check_eq("release_ready_high", a_frame_in_ready, 1'b1);

    $display("rx frame 11 22 33 44, ready=1");
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33);
    #1 check_eq("rx_partial_valid", a_frame_out_valid, 1'b0);
    send_rx(8'h44);
    #1;
    check_eq("rx_lsb_valid", a_frame_out_valid, 1'b1);
    check_eq("rx_lsb_frame", a_frame_out, 32'h44332211);
    check_eq("rx_msb_valid", b_frame_out_valid, 1'b1);
    check_eq("rx_msb_frame", b_frame_out, 32'h11223344);
    tick();
    #1 check_eq("rx_valid_one_cycle", a_frame_out_valid, 1'b0);

    $display("rx partial 11 22 then 20 idle clocks");
    send_rx(8'h11); send_rx(8'h22);
    tcount = 0; tfirst = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_rx_timeout) begin
        tcount++;
        if (tfirst < 0) tfirst = i;
      end
      tick();
    end
    check_eq("timeout_count", tcount, 1);
    check_eq("timeout_cycle", tfirst, 15);
    check_eq("timeout_cleared", a_frame_out, 32'h0);
    $display("rx frame AA BB CC DD after timeout");
    send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hCC); send_rx(8'hDD);
    #1;
    check_eq("post_timeout_valid", a_frame_out_valid, 1'b1);
    check_eq("post_timeout_frame", a_frame_out, 32'hDDCCBBAA);
    tick();

    $display("rx frame 01 02 03 04 with ready=0, then overrun bytes");
    frame_out_ready = 1'b0;
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    #1 check_eq("bp_frame", a_frame_out, 32'h04030201);
    send_rx(8'hEE); send_rx(8'hFF);
    #1;
    check_eq("bp_overrun", a_overrun_cnt, 8'd2);
    check_eq("bp_frame_stable", a_frame_out, 32'h04030201);
    check_eq("bp_valid_held", a_frame_out_valid, 1'b1);
    rx_byte = 8'h55; rx_byte_valid = 1'b1; frame_out_ready = 1'b1;
    tick();
    rx_byte_valid = 1'b0; frame_out_ready = 1'b0;
    #1;
    check_eq("hs_valid_low", a_frame_out_valid, 1'b0);
    check_eq("hs_overrun_kept", a_overrun_cnt, 8'd2);
    check_eq("hs_lane0", a_frame_out[7:0], 8'h55);
    send_rx(8'h66); send_rx(8'h77); send_rx(8'h88);
    #1;
    check_eq("hs_next_frame", a_frame_out, 32'h88776655);
    check_eq("hs_next_valid", a_frame_out_valid, 1'b1);
    $display("rx 260 overrun bytes");
    repeat (260) send_rx(8'h99);
    #1;
    check_eq("overrun_saturate", a_overrun_cnt, 8'hFF);
    check_eq("overrun_frame_stable", a_frame_out, 32'h88776655);
    frame_out_ready = 1'b1;
    tick();
    #1 check_eq("drain_valid_low", a_frame_out_valid, 1'b0);

    $display("tx frame DEADBEEF, ready 1-of-3");
    exp_tx[0] = 8'hEF; exp_tx[1] = 8'hBE; exp_tx[2] = 8'hAD; exp_tx[3] = 8'hDE;
    frame_in = 32'hDEADBEEF; frame_in_valid = 1'b1;
    #1;
    check_eq("tx_idle_ready", a_frame_in_ready, 1'b1);
    check_eq("tx_idle_valid", a_tx_byte_valid, 1'b0);
    tick();
    frame_in_valid = 1'b0;
    #1;
    check_eq("tx_first_valid", a_tx_byte_valid, 1'b1);
    check_eq("tx_first_byte_lsb", a_tx_byte, 8'hEF);
    check_eq("tx_first_byte_msb", b_tx_byte, 8'hDE);
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      tx_byte_ready = (c % 3 == 2);
      #1;
      check_eq("tx_busy_ready", a_frame_in_ready, 1'b0);
      check_eq("tx_byte_stable", a_tx_byte, exp_tx[k]);
      if (tx_byte_ready) begin
        check_eq("tx_accept_valid", a_tx_byte_valid, 1'b1);
        check_eq("tx_done_edge", a_tx_done, (k == 3));
        $display("tx byte %0d = 0x%02h", k, a_tx_byte);
        k++;
      end else begin
        check_eq("tx_done_idle", a_tx_done, 1'b0);
      end
      tick();
    end
    tx_byte_ready = 1'b0;
    check_eq("tx_byte_count", k, 4);
    #1;
    check_eq("tx_after_ready", a_frame_in_ready, 1'b1);
    check_eq("tx_after_valid", a_tx_byte_valid, 1'b0);

    $display("reset mid-frame: 2 rx bytes, 1 tx byte");
    send_rx(8'h11); send_rx(8'h22);
    frame_in = 32'h01020304; frame_in_valid = 1'b1;
    tick();
    frame_in_valid = 1'b0; tx_byte_ready = 1'b1;
    tick();
    tx_byte_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_frame_out", a_frame_out, 32'h0);
    check_eq("mid_rst_out_valid", a_frame_out_valid, 1'b0);
    check_eq("mid_rst_tx_valid", a_tx_byte_valid, 1'b0);
    check_eq("mid_rst_tx_byte", a_tx_byte, 8'h0);
    check_eq("mid_rst_in_ready", a_frame_in_ready, 1'b0);
    check_eq("mid_rst_overrun", a_overrun_cnt, 8'h0);
    check_eq("mid_rst_timeout", a_rx_timeout, 1'b0);
    check_eq("mid_rst_tx_done", a_tx_done, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    #1;
    check_eq("post_rst_in_ready", a_frame_in_ready, 1'b1);
    check_eq("post_rst_tx_valid", a_tx_byte_valid, 1'b0);
    $display("rx frame A1 B2 C3 D4 after reset");
    send_rx(8'hA1); send_rx(8'hB2); send_rx(8'hC3); send_rx(8'hD4);
    #1;
    check_eq("post_rst_frame", a_frame_out, 32'hD4C3B2A1);
    check_eq("post_rst_valid", a_frame_out_valid, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
